// File: rtl/sccb_responder.sv
// SCCB/I2C target modelling the OV7670 register port: oversampled SCL/SDA decode,
// open-drain ACK/read drive, 256x8 register file with write reporting.
module sccb_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h21,
  parameter logic [7:0] PID_VAL  = 8'h76,
  parameter logic [7:0] VER_VAL  = 8'h73
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       reg_we,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       busy
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] DEVADDR   = 4'd1;
  localparam logic [3:0] ACK_DEV   = 4'd2;
  localparam logic [3:0] SUBADDR   = 4'd3;
  localparam logic [3:0] ACK_SUB   = 4'd4;
  localparam logic [3:0] WDATA     = 4'd5;
  localparam logic [3:0] ACK_WDATA = 4'd6;
  localparam logic [3:0] RDATA     = 4'd7;
  localparam logic [3:0] RACK      = 4'd8;
  localparam logic [3:0] IGNORE    = 4'd9;

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_d;
  logic       sda_d;
  logic       scl;
  logic       sda;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  logic [3:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] ptr;
  logic       rw;
  logic       flag;
  logic [7:0] rx_byte;
  logic [7:0] rd_byte;
  logic       last_bit;

  logic [7:0] regfile [256];

  assign scl       = scl_sync[1];
  assign sda       = sda_sync[1];
  assign scl_rise  = scl & ~scl_d;
  assign scl_fall  = ~scl & scl_d;
  assign start_det = scl & scl_d & sda_d & ~sda;
  assign stop_det  = scl & scl_d & ~sda_d & sda;
  assign rx_byte   = {shreg[6:0], sda};
  assign rd_byte   = regfile[ptr];
  assign last_bit  = (bit_cnt == 3'd7);
  assign dbg_data  = regfile[dbg_addr];

  // In ACK states sda_oe doubles as the phase marker: the first detected fall
  // starts the ACK slot, the second one ends it. In RDATA/RACK, flag marks
  // "byte shifted out" and "master ACKed" respectively.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_sync  <= 2'b11;
      sda_sync  <= 2'b11;
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      ptr       <= 8'h00;
      rw        <= 1'b0;
      flag      <= 1'b0;
      sda_oe    <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      busy      <= 1'b0;
      for (int i = 0; i < 256; i++)
        regfile[i[7:0]] <= (i == 10) ? PID_VAL : (i == 11) ? VER_VAL : 8'h00;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_d    <= scl;
      sda_d    <= sda;
      reg_we   <= 1'b0;
      if (start_det) begin
        state   <= DEVADDR;
        bit_cnt <= 3'd0;
        flag    <= 1'b0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= 3'd0;
        flag    <= 1'b0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          DEVADDR:
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state <= ACK_DEV;
                  rw    <= rx_byte[0];
                  busy  <= 1'b1;
                end else begin
                  state <= IGNORE;
                end
              end
            end
          SUBADDR:
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                ptr   <= rx_byte;
                state <= ACK_SUB;
              end
            end
          WDATA:
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                reg_we    <= 1'b1;
                reg_addr  <= ptr;
                reg_wdata <= rx_byte;
                if (ptr != 8'h0A && ptr != 8'h0B)
                  regfile[ptr] <= rx_byte;
                ptr   <= ptr + 8'd1;
                state <= ACK_WDATA;
              end
            end
          ACK_DEV, ACK_SUB, ACK_WDATA:
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= 3'd0;
                if (state == ACK_DEV && rw) begin
                  sda_oe <= ~rd_byte[7];
                  shreg  <= {rd_byte[6:0], 1'b0};
                  state  <= RDATA;
                end else if (state == ACK_DEV) begin
                  state <= SUBADDR;
                end else begin
                  state <= WDATA;
                end
              end
            end
          RDATA:
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit)
                flag <= 1'b1;
            end else if (scl_fall) begin
              if (flag) begin
                flag   <= 1'b0;
                sda_oe <= 1'b0;
                state  <= RACK;
              end else begin
                sda_oe <= ~shreg[7];
                shreg  <= {shreg[6:0], 1'b0};
              end
            end
          RACK:
            if (scl_rise) begin
              if (sda) begin
                state <= IGNORE;
              end else begin
                ptr  <= ptr + 8'd1;
                flag <= 1'b1;
              end
            end else if (scl_fall && flag) begin
              flag    <= 1'b0;
              bit_cnt <= 3'd0;
              sda_oe  <= ~rd_byte[7];
              shreg   <= {rd_byte[6:0], 1'b0};
              state   <= RDATA;
            end
          IGNORE:
            sda_oe <= 1'b0;
          default:
            state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_responder.sv
// Self-checking bench for sccb_responder: a bit-banged SCCB master on an
// open-drain bus, checked against a register-file/pointer model kept here.
module tb_sccb_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_i;
  logic       sda_oe;
  logic       reg_we;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] dbg_addr = 8'h00;
  logic [7:0] dbg_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_mem [256];
  logic [15:0] we_q [$];
  logic [7:0]  wbuf [$];
  logic        oe_seen = 1'b0;

  assign sda_i = sda_m & ~sda_oe;

  sccb_responder dut (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl_m),
    .sda_i     (sda_i),
    .sda_oe    (sda_oe),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Every high cycle of reg_we is logged, so a stretched pulse shows up as an extra entry.
  always @(negedge clk) begin
    if (reg_we) we_q.push_back({reg_addr, reg_wdata});
    if (sda_oe) oe_seen = 1'b1;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++)
      model_mem[i[7:0]] = (i == 10) ? 8'h76 : (i == 11) ? 8'h73 : 8'h00;
  endtask

  task automatic check_dbg(input string tag, input logic [7:0] a);
    dbg_addr = a;
    #1;
    check_output(tag, 32'(dbg_data), 32'(model_mem[a]));
  endtask

  task automatic quarter();
    repeat (5) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; quarter();
    scl_m = 1'b1; quarter();
    sda_m = 1'b0; quarter();
    scl_m = 1'b0; quarter();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; quarter();
    scl_m = 1'b1; quarter();
    sda_m = 1'b1; quarter();
    quarter();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; quarter();
    scl_m = 1'b1; quarter(); quarter();
    scl_m = 1'b0; quarter();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; quarter();
    scl_m = 1'b1; quarter();
    b = sda_i; quarter();
    scl_m = 1'b0; quarter();
  endtask

  task automatic send_byte(input logic [7:0] v, output logic acked);
    logic [7:0] s;
    logic       b;
    s = v;
    for (int i = 0; i < 8; i++) begin
      write_bit(s[7]);
      s = {s[6:0], 1'b0};
    end
    read_bit(b);
    acked = ~b;
  endtask

  task automatic recv_byte(output logic [7:0] v, input logic master_ack);
    logic b;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v = {v[6:0], b};
    end
    write_bit(~master_ack);
    sda_m = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [7:0] sub);
    logic        ack;
    logic [7:0]  p;
    logic [15:0] exp_q [$];
    we_q.delete();
    bus_start();
    send_byte(8'h42, ack);
    check_output("wr_dev_ack", 32'(ack), 32'd1);
    send_byte(sub, ack);
    check_output("wr_sub_ack", 32'(ack), 32'd1);
    p = sub;
    foreach (wbuf[i]) begin
      send_byte(wbuf[i], ack);
      check_output("wr_data_ack", 32'(ack), 32'd1);
      exp_q.push_back({p, wbuf[i]});
      if (p != 8'h0A && p != 8'h0B) model_mem[p] = wbuf[i];
      p = p + 8'd1;
    end
    check_output("wr_busy_mid", 32'(busy), 32'd1);
    bus_stop();
    quarter();
    check_output("wr_busy_after_stop", 32'(busy), 32'd0);
    check_output("wr_we_count", 32'(we_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < we_q.size())
        check_output("wr_we_entry", 32'(we_q[i]), 32'(exp_q[i]));
  endtask

  task automatic read_txn(input logic [7:0] sub, input int n);
    logic       ack;
    logic [7:0] v;
    bus_start();
    send_byte(8'h42, ack);
    check_output("rd_dev_w_ack", 32'(ack), 32'd1);
    send_byte(sub, ack);
    check_output("rd_sub_ack", 32'(ack), 32'd1);
    bus_stop();
    bus_start();
    send_byte(8'h43, ack);
    check_output("rd_dev_r_ack", 32'(ack), 32'd1);
    check_output("rd_busy", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      recv_byte(v, i != n - 1);
      check_output("rd_data", 32'(v), 32'(model_mem[sub + 8'(i)]));
    end
    check_output("rd_oe_after_nack", 32'(sda_oe), 32'd0);
    bus_stop();
    quarter();
    check_output("rd_busy_after_stop", 32'(busy), 32'd0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] sub;
    int         n;
    int         waited;

    model_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_sda_oe", 32'(sda_oe), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_reg_we", 32'(reg_we), 32'd0);
    check_output("rst_reg_addr", 32'(reg_addr), 32'd0);
    check_output("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    check_dbg("rst_pid", 8'h0A);
    check_dbg("rst_ver", 8'h0B);
    check_dbg("rst_zero", 8'h00);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    wbuf = '{8'h80};
    apply_stimulus(8'h12);
    check_dbg("single_write", 8'h12);

    wbuf = '{8'h11, 8'h22};
    apply_stimulus(8'hFF);
    check_dbg("burst_ff", 8'hFF);
    check_dbg("burst_wrap_00", 8'h00);

    wbuf = '{8'h55};
    apply_stimulus(8'h0A);
    check_dbg("pid_protected", 8'h0A);

    read_txn(8'h0A, 1);
    read_txn(8'hFE, 3);

    we_q.delete();
    oe_seen = 1'b0;
    bus_start();
    send_byte(8'h60, ack);
    check_output("wrong_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h12, ack);
    check_output("wrong_addr_sub_ack", 32'(ack), 32'd0);
    check_output("wrong_addr_busy", 32'(busy), 32'd0);
    bus_stop();
    check_output("wrong_addr_oe_seen", 32'(oe_seen), 32'd0);
    check_output("wrong_addr_we", 32'(we_q.size()), 32'd0);
    wbuf = '{8'h3C};
    apply_stimulus(8'h30);

    we_q.delete();
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'h30, ack);
    for (int i = 0; i < 4; i++) write_bit(i[0]);
    bus_stop();
    quarter();
    check_output("partial_stop_we", 32'(we_q.size()), 32'd0);
    check_output("partial_stop_busy", 32'(busy), 32'd0);
    check_dbg("partial_stop_reg", 8'h30);

    we_q.delete();
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'h31, ack);
    for (int i = 0; i < 4; i++) write_bit(~i[0]);
    bus_start();
    send_byte(8'h42, ack);
    check_output("rstart_dev_ack", 32'(ack), 32'd1);
    send_byte(8'h32, ack);
    send_byte(8'h99, ack);
    bus_stop();
    quarter();
    model_mem[8'h32] = 8'h99;
    check_output("rstart_we_count", 32'(we_q.size()), 32'd1);
    if (we_q.size() > 0)
      check_output("rstart_we_entry", 32'(we_q[0]), 32'h3299);
    check_dbg("rstart_partial_reg", 8'h31);
    check_dbg("rstart_write_reg", 8'h32);

    for (int t = 0; t < 6; t++) begin
      sub = 8'($urandom());
      n = $urandom_range(1, 3);
      wbuf.delete();
      repeat (n) wbuf.push_back(8'($urandom()));
      apply_stimulus(sub);
      read_txn(sub, n);
      check_dbg("rand_dbg", 8'($urandom()));
    end

    wbuf = '{8'h5A};
    apply_stimulus(8'h12);
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'h12, ack);
    bus_stop();
    bus_start();
    send_byte(8'h43, ack);
    waited = 0;
    while (sda_oe !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_output("rdata_oe_before_reset", 32'(sda_oe), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_output("midreset_sda_oe", 32'(sda_oe), 32'd0);
    check_output("midreset_busy", 32'(busy), 32'd0);
    model_reset();
    check_dbg("midreset_pid", 8'h0A);
    check_dbg("midreset_cleared", 8'h12);
    bus_stop();
    wbuf = '{8'hA7};
    apply_stimulus(8'h44);
    check_dbg("post_reset_write", 8'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
